// File: rtl/gowin_pll_phase_ctrl.sv
// rtl/gowin_pll_phase_ctrl.sv - multi-channel PSDA/DUTYDA dynamic phase controller for rPLLs
// Steps one channel at a time; each PSDA change is followed by a settle window and a lock wait.
module gowin_pll_phase_ctrl #(
  parameter int NUM_CH        = 2,
  parameter int STEP_SIZE     = 1,
  parameter int SETTLE_CYCLES = 16,
  parameter int LOCK_TIMEOUT  = 4096,
  parameter int INIT_PHASE    = 0,
  parameter int DUTY_OFFSET   = 8,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [CH_W-1:0]       cmd_ch_i,
  input  logic [1:0]            cmd_op_i,
  input  logic [3:0]            cmd_phase_i,
  input  logic [NUM_CH-1:0]     pll_lock_i,
  output logic [4*NUM_CH-1:0]   psda_o,
  output logic [4*NUM_CH-1:0]   dutyda_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int CNT_MAX = (SETTLE_CYCLES > LOCK_TIMEOUT) ? SETTLE_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [3:0] STEP4   = 4'(STEP_SIZE);
  localparam logic [3:0] PH_MASK = ~4'(STEP_SIZE - 1);
  localparam logic [3:0] INIT4   = 4'(INIT_PHASE);
  localparam logic [3:0] DOFF4   = 4'(DUTY_OFFSET);

  localparam logic [1:0] OP_DOWN   = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_PLAN, S_APPLY, S_SETTLE, S_WAIT_LOCK, S_DONE
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CH_W-1:0]     ch_q;
  logic [1:0]          op_q;
  logic [3:0]          target_q;
  logic [3:0]          next_q;
  logic [4*NUM_CH-1:0] psda_q;
  logic [4*NUM_CH-1:0] dutyda_q;
  logic                done_q;
  logic                err_q;

  logic [3:0] cur_psda;
  logic       cur_lock;
  logic       ch_ok;
  logic [3:0] delta_d;
  logic       up_d;
  logic       move_d;
  logic [3:0] next_d;

  always_comb begin
    cur_psda = INIT4;
    cur_lock = 1'b0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (int'(ch_q) == n) begin
        cur_psda = psda_q[4*n +: 4];
        cur_lock = pll_lock_i[n];
      end
    end
    ch_ok   = int'(ch_q) < NUM_CH;
    delta_d = target_q - cur_psda;
    up_d    = 1'b1;
    move_d  = 1'b1;
    // Seek/preset: shortest way round the 16-position circle, ties go up.
    if (op_q == OP_DOWN) begin
      up_d = 1'b0;
    end else if (op_q[1]) begin
      if (delta_d == 4'd0) begin
        move_d = 1'b0;
      end else if (delta_d > 4'd8) begin
        up_d = 1'b0;
      end
    end
    next_d = up_d ? (cur_psda + STEP4) : (cur_psda - STEP4);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ch_q     <= '0;
      op_q     <= '0;
      target_q <= '0;
      next_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        psda_q[4*n +: 4]   <= INIT4;
        dutyda_q[4*n +: 4] <= INIT4 + DOFF4;
      end
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid_i) begin
            ch_q     <= cmd_ch_i;
            op_q     <= cmd_op_i;
            target_q <= (cmd_op_i == OP_PRESET) ? INIT4 : (cmd_phase_i & PH_MASK);
            state_q  <= S_PLAN;
          end
        end
        S_PLAN: begin
          if (!ch_ok) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else if (!move_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            next_q  <= next_d;
            state_q <= S_APPLY;
          end
        end
        S_APPLY: begin
          for (int n = 0; n < NUM_CH; n++) begin
            if (int'(ch_q) == n) begin
              psda_q[4*n +: 4]   <= next_q;
              dutyda_q[4*n +: 4] <= next_q + DOFF4;
            end
          end
          cnt_q   <= '0;
          state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_LOCK;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_LOCK: begin
          if (cur_lock) begin
            cnt_q <= '0;
            if (op_q[1]) begin
              state_q <= S_PLAN;
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else if (cnt_q == LOCK_LAST) begin
            cnt_q   <= '0;
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o = (state_q == S_IDLE) && !rst_i;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign psda_o      = psda_q;
  assign dutyda_o    = dutyda_q;

endmodule

// File: tb/tb_gowin_pll_phase_ctrl.sv
// tb/tb_gowin_pll_phase_ctrl.sv - scoreboard bench for gowin_pll_phase_ctrl
// Three channels, SETTLE_CYCLES=16, LOCK_TIMEOUT=32; latencies are edges from the accepting edge.
module tb_gowin_pll_phase_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ch;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_phase;
  logic [2:0]  pll_lock;
  logic [11:0] psda;
  logic [11:0] dutyda;
  logic        busy;
  logic        done;
  logic        err;

  gowin_pll_phase_ctrl #(
    .NUM_CH(3), .STEP_SIZE(1), .SETTLE_CYCLES(16), .LOCK_TIMEOUT(32),
    .INIT_PHASE(0), .DUTY_OFFSET(8)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_ch_i(cmd_ch), .cmd_op_i(cmd_op), .cmd_phase_i(cmd_phase), .pll_lock_i(pll_lock),
    .psda_o(psda), .dutyda_o(dutyda), .busy_o(busy), .done_o(done), .err_o(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] psda; logic [11:0] duty; int gap; } chg_t;
  typedef struct { logic err; logic [11:0] psda; logic [11:0] duty; int lat; } done_t;

  chg_t  chg_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    acc_edge = 0;
  int    last_evt = 0;
  logic  mon_en = 1'b0;
  logic [11:0] prev_psda;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_chg(input logic [11:0] p, input logic [11:0] d, input int gap);
    chg_t e;
    e.psda = p; e.duty = d; e.gap = gap;
    chg_q.push_back(e);
  endtask

  task automatic exp_done(input logic e_err, input logic [11:0] p, input logic [11:0] d, input int lat);
    done_t e;
    e.err = e_err; e.psda = p; e.duty = d; e.lat = lat;
    done_q.push_back(e);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples on the falling edge, after everything the rising edge produced has settled.
  always @(negedge clk) begin
    chg_t  c;
    done_t d;
    if (!mon_en) begin
      prev_psda = psda;
    end else begin
      if (psda !== prev_psda) begin
        if (chg_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL psda_unexpected: got 0x%0h with no change pending", psda);
        end else begin
          c = chg_q.pop_front();
          check("psda_step", 32'(psda), 32'(c.psda));
          check("dutyda_step", 32'(dutyda), 32'(c.duty));
          if (c.gap >= 0) check("step_gap", cyc - last_evt, c.gap);
        end
        last_evt  = cyc;
        prev_psda = psda;
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got done=1 with no completion pending");
        end else begin
          d = done_q.pop_front();
          check("done_err", 32'(err), 32'(d.err));
          check("done_psda", 32'(psda), 32'(d.psda));
          check("done_dutyda", 32'(dutyda), 32'(d.duty));
          check("done_latency", cyc - acc_edge, d.lat);
        end
      end
      if (err && !done) begin
        checks++; errors++;
        $display("FAIL err_without_done: got err=1 done=0 required err only with done");
      end
      if (cmd_valid && cmd_ready) begin
        acc_edge = cyc + 1;
        last_evt = cyc + 1;
      end
    end
  end

  task automatic send(input logic [1:0] ch, input logic [1:0] op, input logic [3:0] ph);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!cmd_ready) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got cmd_ready=0 required 1 within 200 cycles");
    end
    cmd_ch = ch; cmd_op = op; cmd_phase = ph; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    if (busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: got busy=1 required 0 within 2000 cycles");
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_ch = '0; cmd_op = '0; cmd_phase = '0;
    pll_lock = 3'b111;
    repeat (3) @(posedge clk);
    #1;
    check("ready_in_reset", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_psda", 32'(psda), 32'h000);
    check("reset_dutyda", 32'(dutyda), 32'h888);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_ready", 32'(cmd_ready), 32'd1);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // step up ch0
    exp_chg(12'h001, 12'h889, 2);
    exp_done(1'b0, 12'h001, 12'h889, 19);
    send(2'd0, 2'b01, 4'd0); wait_idle();

    // step down ch1 wraps 0 -> 15
    exp_chg(12'h0F1, 12'h879, 2);
    exp_done(1'b0, 12'h0F1, 12'h879, 19);
    send(2'd1, 2'b00, 4'd0); wait_idle();

    // seek ch1 15 -> 12, three steps down
    exp_chg(12'h0E1, 12'h869, 2);
    exp_chg(12'h0D1, 12'h859, 19);
    exp_chg(12'h0C1, 12'h849, 19);
    exp_done(1'b0, 12'h0C1, 12'h849, 58);
    send(2'd1, 2'b10, 4'd12); wait_idle();

    // preset ch0 1 -> 0
    exp_chg(12'h0C0, 12'h848, 2);
    exp_done(1'b0, 12'h0C0, 12'h848, 20);
    send(2'd0, 2'b11, 4'd0); wait_idle();

    // seek ch0 0 -> 8: tie at delta 8 goes up
    for (int k = 1; k <= 8; k++) begin
      exp_chg(12'h0C0 | 12'(k), 12'h840 | 12'((k + 8) % 16), (k == 1) ? 2 : 19);
    end
    exp_done(1'b0, 12'h0C8, 12'h840, 153);
    send(2'd0, 2'b10, 4'd8); wait_idle();

    // seek to current phase: nothing moves
    exp_done(1'b0, 12'h0C8, 12'h840, 1);
    send(2'd0, 2'b10, 4'd8); wait_idle();

    // lock timeout on ch2: one step applied, rest abandoned
    pll_lock = 3'b011;
    exp_chg(12'h1C8, 12'h940, 2);
    exp_done(1'b1, 12'h1C8, 12'h940, 50);
    send(2'd2, 2'b10, 4'd4); wait_idle();
    pll_lock = 3'b111;

    exp_chg(12'h2C8, 12'hA40, 2);
    exp_done(1'b0, 12'h2C8, 12'hA40, 19);
    send(2'd2, 2'b01, 4'd0); wait_idle();

    // invalid channel
    exp_done(1'b1, 12'h2C8, 12'hA40, 1);
    send(2'd3, 2'b01, 4'd0); wait_idle();

    // reset in the middle of seek ch1 12 -> 4 (goes up)
    exp_chg(12'h2D8, 12'hA50, 2);
    exp_chg(12'h2E8, 12'hA60, 19);
    exp_chg(12'h000, 12'h888, -1);
    send(2'd1, 2'b10, 4'd4);
    repeat (24) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_psda", 32'(psda), 32'h000);
    check("midrst_dutyda", 32'(dutyda), 32'h888);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd0);
    rst = 1'b0;
    #1;
    check("postrst_ready", 32'(cmd_ready), 32'd1);

    exp_chg(12'h001, 12'h889, 2);
    exp_done(1'b0, 12'h001, 12'h889, 19);
    send(2'd0, 2'b01, 4'd0); wait_idle();

    repeat (5) @(posedge clk);
    #1;
    check("pending_changes", chg_q.size(), 32'd0);
    check("pending_dones", done_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
